dataselect_32_bit_4dist: RTL and testbench
==========================================

Name: dataselect_32_bit_4dist

Overview:
- 1-to-4 registered data distributor for the multicycle datapath; the write-side counterpart of the 4-input select muxes.
- Takes one 32-bit result plus a 2-bit destination select and captures it into one of four holding registers.
- Each holding register has a valid flag. A per-slot consume handshake frees the slot.
- Back-pressures the producer when the addressed slot is still occupied.

Parameters:
- WIDTH, 32, data width of the input and of each holding register.
- RESET_VALUE, 0, value loaded into every holding register on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  data to distribute
- ctrl  input  2  destination select: 2'b00 slot 1, 2'b01 slot 2, 2'b10 slot 3, 2'b11 slot 4
- wr_en  input  1  producer write request
- wr_ready  output  1  combinational; addressed slot can accept this cycle
- consume  input  4  bit i = consumer i takes slot i+1 this cycle
- data_out1..data_out4  output  WIDTH each  holding registers (registered)
- valid  output  4  bit i = slot i+1 holds unconsumed data (registered)
- occupancy  output  3  registered count of set valid bits, 0..4

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - data_out1..4 = RESET_VALUE
  - valid = 4'b0000
  - occupancy = 0
  - drop_cnt = 0 when compiled in
  - No pending state survives reset.
- Ready rule: wr_ready = ~valid[ctrl] | consume[ctrl]. Purely combinational from current valid, ctrl and consume; no dependence on wr_en.
- Accept: accept = wr_en & wr_ready. At the next rising edge:
  - data_out[ctrl] <= data_in
  - valid[ctrl] <= 1
  - Latency 1 cycle from accept to visible data/valid.
- Refused write: wr_en & ~wr_ready. No register changes and data_in is discarded. The producer must hold data_in/ctrl and retry; the block does not queue.
- Consume: consume[i] & valid[i], with slot i not being written this cycle:
  - valid[i] <= 0
  - data_out of slot i retains its value; it is not cleared.
- Consume of an invalid slot is ignored: no state change and no error.
- Write and consume on the same slot in the same cycle: the write is accepted and valid stays 1. The new data is visible next cycle, and the consumer has taken the old data.
- Multiple consume bits may be set in one cycle; each is handled independently. At most one slot is written per cycle.
- Non-addressed slots are never modified by a write.
- Occupancy: registered popcount of the next-state valid. Updates in the same edge as valid and never exceeds 4.
- wr_en low: wr_ready is still driven per the ready rule; no write occurs.

Optional Feature:
- Macro: DATASELECT_DROPCNT_EN
- Defined:
  - Adds output port drop_cnt, 8 bits, registered.
  - Increments by 1 on each cycle with wr_en & ~wr_ready.
  - Saturates at 8'hFF.
  - Resets to 0 with rst_n.
  - Not cleared by any other input.
- Undefined: the drop_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then fill: rst_n low, then high. Write 32'h11111111..32'h44444444 with ctrl 00..11 on four consecutive cycles → one cycle after each write the matching data_outN is set; valid steps 0001, 0011, 0111, 1111; occupancy steps 1..4; wr_ready stays 1 throughout.
- Back-pressure: slot 2 valid, wr_en=1, ctrl=01, data_in=32'hDEADBEEF, consume=0 → wr_ready=0; data_out2 unchanged; drop_cnt increments by 1 per stalled cycle if compiled in.
- Same-cycle write and consume: slot 3 holds 32'hAAAA0000; ctrl=10, data_in=32'hBBBB0000, wr_en=1, consume=4'b0100 → wr_ready=1; next cycle data_out3=32'hBBBB0000, valid[2]=1, occupancy unchanged.
- Consume retains data: slot 4 = 32'hCAFEF00D, consume=4'b1000 → next cycle valid[3]=0, data_out4 still 32'hCAFEF00D, occupancy decreases by 1. Consume on an empty slot 1 → no change.
- Async reset mid-operation: all slots full, drop_cnt=5. Pulse rst_n low between clock edges → outputs go to RESET_VALUE, valid=0, occupancy=0, drop_cnt=0 immediately without waiting for a clock edge.
- Saturation (DATASELECT_DROPCNT_EN defined): hold a refused write for 300 cycles → drop_cnt = 8'hFF and stays there.

Source files
------------

// File: rtl/dataselect_32_bit_4dist.sv
// 1-to-4 registered data distributor with per-slot valid/consume handshake.
// Optional refused-write counter (drop_cnt) enabled by DATASELECT_DROPCNT_EN.
module dataselect_32_bit_4dist #(
  parameter int unsigned          WIDTH       = 32,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       ctrl,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [3:0]       consume,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic [WIDTH-1:0] data_out4,
  output logic [3:0]       valid,
  output logic [2:0]       occupancy
`ifdef DATASELECT_DROPCNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  logic [WIDTH-1:0] data_q [4];
  logic             accept;
  logic [3:0]       wr_sel;
  logic [3:0]       valid_nxt;
  logic [2:0]       occ_nxt;

  // A slot is writable if empty, or if its consumer drains it this same cycle.
  assign wr_ready = ~valid[ctrl] | consume[ctrl];
  assign accept   = wr_en & wr_ready;
  assign wr_sel   = accept ? (4'b0001 << ctrl) : 4'b0000;

  // Write wins over consume on the same slot, so valid stays set.
  assign valid_nxt = (valid & ~consume) | wr_sel;

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      occ_nxt = occ_nxt + 3'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= RESET_VALUE;
      end
      valid     <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          data_q[i] <= data_in;
        end
      end
      valid     <= valid_nxt;
      occupancy <= occ_nxt;
    end
  end

  assign data_out1 = data_q[0];
  assign data_out2 = data_q[1];
  assign data_out3 = data_q[2];
  assign data_out4 = data_q[3];

`ifdef DATASELECT_DROPCNT_EN
  logic refused;

  assign refused = wr_en & ~wr_ready;

  // Saturating count of producer stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (refused && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dataselect_32_bit_4dist.sv
// Directed self-checking bench for dataselect_32_bit_4dist.
// Drop-counter checks are active when DATASELECT_DROPCNT_EN is defined.
module tb_dataselect_32_bit_4dist;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [1:0]  ctrl;
  logic        wr_en;
  logic        wr_ready;
  logic [3:0]  consume;
  logic [31:0] data_out1, data_out2, data_out3, data_out4;
  logic [3:0]  valid;
  logic [2:0]  occupancy;
`ifdef DATASELECT_DROPCNT_EN
  logic [7:0]  drop_cnt;
`endif

  logic [31:0] dout [4];
  int          n_cmp;
  int          n_err;

  assign dout[0] = data_out1;
  assign dout[1] = data_out2;
  assign dout[2] = data_out3;
  assign dout[3] = data_out4;

  dataselect_32_bit_4dist #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .ctrl      (ctrl),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .consume   (consume),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .data_out4 (data_out4),
    .valid     (valid),
    .occupancy (occupancy)
`ifdef DATASELECT_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; ctrl = 2'b00; wr_en = 1'b0; consume = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if ({data_out1, data_out2, data_out3, data_out4} !== 128'h0) begin
      n_err++; $display("FAIL reset_data got %h %h %h %h want 0", data_out1, data_out2, data_out3, data_out4);
    end
    n_cmp++;
    if ({valid, occupancy} !== 7'b0) begin
      n_err++; $display("FAIL reset_valid_occ got valid=%b occ=%0d want 0000/0", valid, occupancy);
    end
`ifdef DATASELECT_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 8'h00) begin
      n_err++; $display("FAIL reset_drop got %h want 00", drop_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] exp_d;
    logic [3:0]  exp_v;
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'h11111111 * (i + 1);
      exp_v = 4'((1 << (i + 1)) - 1);
      wr_en = 1'b1; ctrl = 2'(i); data_in = exp_d;
      #1;
      n_cmp++;
      if (wr_ready !== 1'b1) begin
        n_err++; $display("FAIL fill_ready slot%0d got %b want 1", i + 1, wr_ready);
      end
      tick();
      n_cmp++;
      if (dout[i] !== exp_d) begin
        n_err++; $display("FAIL fill_data slot%0d got %h want %h", i + 1, dout[i], exp_d);
      end
      n_cmp++;
      if (valid !== exp_v || occupancy !== 3'(i + 1)) begin
        n_err++; $display("FAIL fill_valid slot%0d got %b/%0d want %b/%0d", i + 1, valid, occupancy, exp_v, i + 1);
      end
    end
    wr_en = 1'b0;
    n_cmp++;
    if ({data_out1, data_out2, data_out3} !== {32'h11111111, 32'h22222222, 32'h33333333}) begin
      n_err++; $display("FAIL fill_others got %h %h %h want 11111111 22222222 33333333", data_out1, data_out2, data_out3);
    end
  endtask

  task automatic test_back_pressure();
    wr_en = 1'b1; ctrl = 2'b01; data_in = 32'hDEADBEEF; consume = 4'b0000;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready got %b want 0", wr_ready);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (data_out2 !== 32'h22222222 || valid !== 4'b1111 || occupancy !== 3'd4) begin
      n_err++; $display("FAIL bp_hold got %h %b %0d want 22222222 1111 4", data_out2, valid, occupancy);
    end
`ifdef DATASELECT_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 8'd5) begin
      n_err++; $display("FAIL bp_drop got %0d want 5", drop_cnt);
    end
`endif
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_noen got %b want 0", wr_ready);
    end
    consume = 4'b0010;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_consume got %b want 1", wr_ready);
    end
    consume = 4'b0000;
    tick();
`ifdef DATASELECT_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 8'd5) begin
      n_err++; $display("FAIL bp_drop_idle got %0d want 5", drop_cnt);
    end
`endif
  endtask

  task automatic test_same_cycle();
    consume = 4'b0100; wr_en = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 4'b1011 || occupancy !== 3'd3 || data_out3 !== 32'h33333333) begin
      n_err++; $display("FAIL sc_drain got %b %0d %h want 1011 3 33333333", valid, occupancy, data_out3);
    end
    consume = 4'b0000; wr_en = 1'b1; ctrl = 2'b10; data_in = 32'hAAAA0000;
    tick();
    consume = 4'b0100; data_in = 32'hBBBB0000;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL sc_ready got %b want 1", wr_ready);
    end
    n_cmp++;
    if (data_out3 !== 32'hAAAA0000) begin
      n_err++; $display("FAIL sc_old got %h want aaaa0000", data_out3);
    end
    tick();
    wr_en = 1'b0; consume = 4'b0000;
    n_cmp++;
    if (data_out3 !== 32'hBBBB0000 || valid !== 4'b1111 || occupancy !== 3'd4) begin
      n_err++; $display("FAIL sc_new got %h %b %0d want bbbb0000 1111 4", data_out3, valid, occupancy);
    end
  endtask

  task automatic test_consume_retain();
    wr_en = 1'b1; ctrl = 2'b11; data_in = 32'hCAFEF00D; consume = 4'b1000;
    tick();
    wr_en = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 4'b0111 || occupancy !== 3'd3 || data_out4 !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL cr_slot4 got %b %0d %h want 0111 3 cafef00d", valid, occupancy, data_out4);
    end
    consume = 4'b0011;
    tick();
    n_cmp++;
    if (valid !== 4'b0100 || occupancy !== 3'd1 || data_out1 !== 32'h11111111 || data_out2 !== 32'h22222222) begin
      n_err++; $display("FAIL cr_multi got %b %0d %h %h want 0100 1 11111111 22222222", valid, occupancy, data_out1, data_out2);
    end
    consume = 4'b0001;
    tick();
    consume = 4'b0000;
    n_cmp++;
    if (valid !== 4'b0100 || occupancy !== 3'd1 || data_out1 !== 32'h11111111) begin
      n_err++; $display("FAIL cr_empty got %b %0d %h want 0100 1 11111111", valid, occupancy, data_out1);
    end
    ctrl = 2'b00;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL cr_ready_empty got %b want 1", wr_ready);
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1;
    ctrl = 2'b00; data_in = 32'h01010101; tick();
    ctrl = 2'b01; data_in = 32'h02020202; tick();
    ctrl = 2'b11; data_in = 32'h04040404; tick();
    wr_en = 1'b0;
    n_cmp++;
    if (valid !== 4'b1111 || occupancy !== 3'd4) begin
      n_err++; $display("FAIL ar_pre got %b %0d want 1111 4", valid, occupancy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out1, data_out2, data_out3, data_out4} !== 128'h0 || valid !== 4'b0 || occupancy !== 3'd0) begin
      n_err++; $display("FAIL ar_now got %h %h %h %h %b %0d want zeros", data_out1, data_out2, data_out3, data_out4, valid, occupancy);
    end
`ifdef DATASELECT_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 8'h00) begin
      n_err++; $display("FAIL ar_drop got %h want 00", drop_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (valid !== 4'b0 || occupancy !== 3'd0) begin
      n_err++; $display("FAIL ar_post got %b %0d want 0000 0", valid, occupancy);
    end
  endtask

  task automatic test_saturation();
    wr_en = 1'b1; ctrl = 2'b00; data_in = 32'h5A5A5A5A; consume = 4'b0000;
    tick();
    data_in = 32'h0BAD0BAD;
    for (int i = 0; i < 254; i++) tick();
`ifdef DATASELECT_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 8'hFE) begin
      n_err++; $display("FAIL sat_fe got %h want fe", drop_cnt);
    end
`endif
    for (int i = 0; i < 46; i++) tick();
`ifdef DATASELECT_DROPCNT_EN
    n_cmp++;
    if (drop_cnt !== 8'hFF) begin
      n_err++; $display("FAIL sat_ff got %h want ff", drop_cnt);
    end
`endif
    n_cmp++;
    if (data_out1 !== 32'h5A5A5A5A || valid !== 4'b0001 || occupancy !== 3'd1) begin
      n_err++; $display("FAIL sat_hold got %h %b %0d want 5a5a5a5a 0001 1", data_out1, valid, occupancy);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_back_pressure();
    test_same_cycle();
    test_consume_retain();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
